// File: rtl/hba_pkg.sv
// hba_pkg: shared definitions for the HBA register slave.
// FSM state encoding, default bus widths and abus field placement.
package hba_pkg;

  // Default geometry of a peripheral slot on the HBA bus
  localparam int unsigned HBA_DEF_DBUS_WIDTH        = 8;
  localparam int unsigned HBA_DEF_PERIPH_ADDR_WIDTH = 4;
  localparam int unsigned HBA_DEF_REG_ADDR_WIDTH    = 8;
  localparam int unsigned HBA_DEF_NUM_WREGS         = 4;
  localparam int unsigned HBA_DEF_NUM_RREGS         = 2;

  // abus = {slot, reg}: register field starts at bit 0, slot sits directly above it
  localparam int unsigned HBA_REG_FIELD_LSB = 0;

  // Transfer handshake states
  typedef enum logic [1:0] {
    HBA_IDLE       = 2'd0,
    HBA_ACK        = 2'd1,
    HBA_WAIT_DESEL = 2'd2
  } hba_state_e;

endpackage

// File: rtl/hba_xfer_ctrl.sv
// hba_xfer_ctrl: slot decode and IDLE/ACK/WAIT_DESEL handshake FSM.
// xfer_go pulses for the single cycle in which a request is accepted, with
// xfer_rnw/xfer_reg valid alongside it; ack_rnw/ack_reg hold the accepted
// request's direction and index while xfer_ack is high.
module hba_xfer_ctrl
  import hba_pkg::*;
#(
  parameter int unsigned PERIPH_ADDR       = 0,
  parameter int unsigned PERIPH_ADDR_WIDTH = HBA_DEF_PERIPH_ADDR_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH    = HBA_DEF_REG_ADDR_WIDTH
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      hba_select,
  input  logic                                      hba_rnw,
  input  logic [PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH-1:0] hba_abus,
  output logic                                      xfer_go,
  output logic                                      xfer_rnw,
  output logic [REG_ADDR_WIDTH-1:0]                 xfer_reg,
  output logic                                      xfer_ack,
  output logic                                      ack_rnw,
  output logic [REG_ADDR_WIDTH-1:0]                 ack_reg
);

  localparam logic [PERIPH_ADDR_WIDTH-1:0] MY_SLOT = PERIPH_ADDR_WIDTH'(PERIPH_ADDR);

  hba_state_e                state_q, state_d;
  logic                      ack_q, ack_d;
  logic                      ack_rnw_q, ack_rnw_d;
  logic [REG_ADDR_WIDTH-1:0] ack_reg_q, ack_reg_d;
  logic [PERIPH_ADDR_WIDTH-1:0] slot;
  logic                      slot_hit;

  // Field extraction and request acceptance
  always_comb begin
    slot     = hba_abus[HBA_REG_FIELD_LSB+REG_ADDR_WIDTH +: PERIPH_ADDR_WIDTH];
    xfer_reg = hba_abus[HBA_REG_FIELD_LSB +: REG_ADDR_WIDTH];
    xfer_rnw = hba_rnw;
    slot_hit = (slot == MY_SLOT);
    xfer_go  = (state_q == HBA_IDLE) && hba_select && slot_hit;
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    ack_rnw_d = ack_rnw_q;
    ack_reg_d = ack_reg_q;
    case (state_q)
      HBA_IDLE: begin
        if (xfer_go) begin
          state_d   = HBA_ACK;
          ack_d     = 1'b1;
          ack_rnw_d = hba_rnw;
          ack_reg_d = xfer_reg;
        end
      end
      HBA_ACK:        state_d = HBA_WAIT_DESEL;
      HBA_WAIT_DESEL: if (!hba_select) state_d = HBA_IDLE;
      default:        state_d = HBA_IDLE;
    endcase
  end

  // FSM state and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= HBA_IDLE;
      ack_q     <= 1'b0;
      ack_rnw_q <= 1'b0;
      ack_reg_q <= '0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      ack_rnw_q <= ack_rnw_d;
      ack_reg_q <= ack_reg_d;
    end
  end

  assign xfer_ack = ack_q;
  assign ack_rnw  = ack_rnw_q;
  assign ack_reg  = ack_reg_q;

endmodule

// File: rtl/hba_reg_slave.sv
// hba_reg_slave: HBA bus responder with writable control registers and
// peripheral-driven read-only status registers.
// Optional feature macro: HBA_REG_SLAVE_INTR_EN (status-change interrupt).
module hba_reg_slave
  import hba_pkg::*;
#(
  parameter int unsigned PERIPH_ADDR       = 0,
  parameter int unsigned DBUS_WIDTH        = HBA_DEF_DBUS_WIDTH,
  parameter int unsigned PERIPH_ADDR_WIDTH = HBA_DEF_PERIPH_ADDR_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH    = HBA_DEF_REG_ADDR_WIDTH,
  parameter int unsigned NUM_WREGS         = HBA_DEF_NUM_WREGS,
  parameter int unsigned NUM_RREGS         = HBA_DEF_NUM_RREGS
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        hba_rnw,
  input  logic                                        hba_select,
  input  logic [PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH-1:0] hba_abus,
  input  logic [DBUS_WIDTH-1:0]                       hba_dbus,
  output logic                                        hba_xferack_slave,
  output logic [DBUS_WIDTH-1:0]                       hba_dbus_slave,
  output logic                                        hba_interrupt_slave,
  output logic [NUM_WREGS*DBUS_WIDTH-1:0]             wreg_out,
  output logic [NUM_WREGS-1:0]                        wr_strobe,
  input  logic [NUM_RREGS*DBUS_WIDTH-1:0]             rreg_in
);

  logic                      xfer_go;
  logic                      xfer_rnw;
  logic [REG_ADDR_WIDTH-1:0] xfer_reg;
  logic                      xfer_ack;
  logic                      ack_rnw;
  logic [REG_ADDR_WIDTH-1:0] ack_reg;

  logic [NUM_WREGS-1:0][DBUS_WIDTH-1:0] wreg_q, wreg_d;
  logic [NUM_WREGS-1:0]                 strobe_q, strobe_d;
  logic [DBUS_WIDTH-1:0]                rdata_q, rdata_d;

  hba_xfer_ctrl #(
    .PERIPH_ADDR      (PERIPH_ADDR),
    .PERIPH_ADDR_WIDTH(PERIPH_ADDR_WIDTH),
    .REG_ADDR_WIDTH   (REG_ADDR_WIDTH)
  ) u_xfer_ctrl (
    .clk       (clk),
    .reset     (reset),
    .hba_select(hba_select),
    .hba_rnw   (hba_rnw),
    .hba_abus  (hba_abus),
    .xfer_go   (xfer_go),
    .xfer_rnw  (xfer_rnw),
    .xfer_reg  (xfer_reg),
    .xfer_ack  (xfer_ack),
    .ack_rnw   (ack_rnw),
    .ack_reg   (ack_reg)
  );

  // Register write, strobe and read-mux selection on request acceptance;
  // unmatched indices fall through to "no write, read zero"
  always_comb begin
    wreg_d   = wreg_q;
    strobe_d = '0;
    rdata_d  = '0;
    if (xfer_go) begin
      for (int unsigned i = 0; i < NUM_WREGS; i++) begin
        if (xfer_reg == REG_ADDR_WIDTH'(i)) begin
          if (xfer_rnw) begin
            rdata_d = wreg_q[i];
          end else begin
            wreg_d[i]   = hba_dbus;
            strobe_d[i] = 1'b1;
          end
        end
      end
      for (int unsigned j = 0; j < NUM_RREGS; j++) begin
        if (xfer_rnw && (xfer_reg == REG_ADDR_WIDTH'(NUM_WREGS + j))) begin
          rdata_d = rreg_in[j*DBUS_WIDTH +: DBUS_WIDTH];
        end
      end
    end
  end

  // Register bank, write strobes and read data register
  always_ff @(posedge clk) begin
    if (!reset) begin
      wreg_q   <= '0;
      strobe_q <= '0;
      rdata_q  <= '0;
    end else begin
      wreg_q   <= wreg_d;
      strobe_q <= strobe_d;
      rdata_q  <= rdata_d;
    end
  end

  assign hba_xferack_slave = xfer_ack;
  assign hba_dbus_slave    = rdata_q;
  assign wreg_out          = wreg_q;
  assign wr_strobe         = strobe_q;

`ifdef HBA_REG_SLAVE_INTR_EN
  localparam logic [REG_ADDR_WIDTH-1:0] RO_LO = REG_ADDR_WIDTH'(NUM_WREGS);
  localparam logic [REG_ADDR_WIDTH-1:0] RO_HI = REG_ADDR_WIDTH'(NUM_WREGS + NUM_RREGS);

  logic [NUM_RREGS*DBUS_WIDTH-1:0] snap_q, snap_d;
  logic                            pend_q, pend_d;
  logic                            ro_read_ack;

  // Sticky change flag; a change at the clearing edge keeps it set
  always_comb begin
    ro_read_ack = xfer_ack && ack_rnw && (ack_reg >= RO_LO) && (ack_reg < RO_HI);
    snap_d      = rreg_in;
    pend_d      = pend_q;
    if (rreg_in != snap_q) begin
      pend_d = 1'b1;
    end else if (ro_read_ack) begin
      pend_d = 1'b0;
    end
  end

  // Snapshot loads the live status during reset so release raises no interrupt
  always_ff @(posedge clk) begin
    if (!reset) begin
      snap_q <= rreg_in;
      pend_q <= 1'b0;
    end else begin
      snap_q <= snap_d;
      pend_q <= pend_d;
    end
  end

  assign hba_interrupt_slave = pend_q;
`else
  logic unused_ack_info;
  assign unused_ack_info     = ^{ack_rnw, ack_reg};
  assign hba_interrupt_slave = 1'b0;
`endif

endmodule
